// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared flit and arbitration types for the router input datapath.
package ravenoc_pkg;
  localparam int FLIT_TYPE_W = 2;
  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_t;
  typedef enum int {
    ARB_FIXED_HI = 0,
    ARB_FIXED_LO = 1,
    ARB_RR       = 2
  } arb_mode_t;
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: single virtual-channel flit FIFO with occupancy count and power-of-two wrap.
module vc_fifo #(
  parameter int FLIT_WIDTH = 34,
  parameter int VC_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_wr_en,
  input  logic [FLIT_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [FLIT_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int AW = $clog2(VC_DEPTH);
  logic [FLIT_WIDTH-1:0] r_mem [VC_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_wr;
  logic                  w_rd;
  assign o_full    = r_count == (AW+1)'(VC_DEPTH);
  assign o_empty   = r_count == '0;
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/vc_input_datapath.sv
// vc_input_datapath: per-VC input buffering for a router port, arbitrated onto one crossbar output
// with optional wormhole locking from HEAD to TAIL.
module vc_input_datapath
  import ravenoc_pkg::*;
#(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VC       = 2,
  parameter int VC_DEPTH   = 4,
  parameter int ARB_MODE   = 2,
  parameter int PKT_LOCK   = 1,
  localparam int VW        = $clog2(N_VC > 1 ? N_VC : 2)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  fin_valid_i,
  input  logic [VW-1:0]         fin_vc_i,
  input  logic [FLIT_WIDTH-1:0] fin_data_i,
  output logic                  fin_ready_o,
  output logic                  fout_valid_o,
  output logic [VW-1:0]         fout_vc_o,
  output logic [FLIT_WIDTH-1:0] fout_data_o,
  input  logic                  fout_ready_i,
  output logic [N_VC-1:0]       vc_full_o,
  output logic [N_VC-1:0]       vc_empty_o,
  output logic [7:0]            drop_cnt_o
);
  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;
  localparam arb_mode_t MODE = arb_mode_t'(ARB_MODE);
  // A presented grant is kept until it transfers, except for unlocked fixed priority.
  localparam bit HOLD_EN = PKT_LOCK != 0 || MODE == ARB_RR;
  logic [FLIT_WIDTH-1:0] w_rd_data [N_VC];
  logic [N_VC-1:0]       w_full;
  logic [N_VC-1:0]       w_empty;
  logic [N_VC-1:0]       w_wr_en;
  logic [N_VC-1:0]       w_rd_en;
  logic                  w_vc_legal;
  logic                  w_sel_full;
  lock_state_t           r_state;
  lock_state_t           w_state_nxt;
  logic [VW-1:0]         r_lock_vc;
  logic [VW-1:0]         w_lock_vc_nxt;
  logic [VW-1:0]         r_rr_ptr;
  logic [VW-1:0]         w_rr_nxt;
  logic                  r_hold;
  logic [VW-1:0]         r_hold_vc;
  logic [7:0]            r_drop_cnt;
  logic [VW-1:0]         w_hi_vc;
  logic [VW-1:0]         w_lo_vc;
  logic [VW-1:0]         w_rr_vc;
  logic                  w_rr_hit;
  logic                  w_arb_vld;
  logic [VW-1:0]         w_arb_vc;
  logic                  w_locked;
  logic                  w_gnt_vld;
  logic [VW-1:0]         w_gnt_vc;
  logic [FLIT_WIDTH-1:0] w_head;
  flit_type_t            w_type;
  logic                  w_xfer;
  logic                  w_done;
  for (genvar g = 0; g < N_VC; g++) begin : g_vc
    vc_fifo #(
      .FLIT_WIDTH(FLIT_WIDTH),
      .VC_DEPTH  (VC_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .arst     (arst),
      .i_wr_en  (w_wr_en[g]),
      .i_wr_data(fin_data_i),
      .i_rd_en  (w_rd_en[g]),
      .o_rd_data(w_rd_data[g]),
      .o_full   (w_full[g]),
      .o_empty  (w_empty[g])
    );
  end
  assign w_vc_legal = {1'b0, fin_vc_i} < (VW+1)'(N_VC);
  always_comb begin
    w_sel_full = 1'b0;
    w_wr_en    = '0;
    w_rd_en    = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (fin_vc_i == VW'(v)) w_sel_full = w_full[v];
      w_wr_en[v] = fin_valid_i && fin_vc_i == VW'(v) && !w_full[v];
      w_rd_en[v] = w_xfer && w_gnt_vc == VW'(v);
    end
  end
  assign fin_ready_o = !w_sel_full;
  // Round-robin picks the lowest requester at or above rr_ptr, else wraps to the lowest overall.
  always_comb begin
    w_hi_vc  = '0;
    w_lo_vc  = '0;
    w_rr_vc  = '0;
    w_rr_hit = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (!w_empty[v]) w_hi_vc = VW'(v);
    end
    for (int v = N_VC - 1; v >= 0; v--) begin
      if (!w_empty[v]) w_lo_vc = VW'(v);
      if (!w_empty[v] && VW'(v) >= r_rr_ptr) begin
        w_rr_hit = 1'b1;
        w_rr_vc  = VW'(v);
      end
    end
  end
  assign w_arb_vld = !(&w_empty);
  assign w_arb_vc  = MODE == ARB_FIXED_HI ? w_hi_vc :
                     MODE == ARB_FIXED_LO ? w_lo_vc :
                     w_rr_hit ? w_rr_vc : w_lo_vc;
  assign w_locked  = r_state == ST_LOCKED;
  assign w_gnt_vc  = w_locked ? r_lock_vc : r_hold ? r_hold_vc : w_arb_vc;
  assign w_gnt_vld = w_locked ? !w_empty[r_lock_vc] : r_hold ? 1'b1 : w_arb_vld;
  assign w_head    = w_rd_data[w_gnt_vc];
  assign w_type    = flit_type_t'(w_head[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
  assign w_xfer    = w_gnt_vld && fout_ready_i;
  assign w_done    = w_xfer && (PKT_LOCK == 0 || w_type == FLIT_TAIL || w_type == FLIT_HEAD_TAIL);
  assign w_rr_nxt  = w_gnt_vc == VW'(N_VC - 1) ? '0 : w_gnt_vc + VW'(1);
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_vc_nxt = r_lock_vc;
    if (PKT_LOCK != 0 && w_xfer && r_state == ST_IDLE && w_type == FLIT_HEAD) begin
      w_state_nxt   = ST_LOCKED;
      w_lock_vc_nxt = w_gnt_vc;
    end else if (PKT_LOCK != 0 && w_xfer && r_state == ST_LOCKED && w_type == FLIT_TAIL) begin
      w_state_nxt = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state    <= ST_IDLE;
      r_lock_vc  <= '0;
      r_rr_ptr   <= '0;
      r_hold     <= 1'b0;
      r_hold_vc  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_vc <= w_lock_vc_nxt;
      if (w_done) r_rr_ptr <= w_rr_nxt;
      r_hold    <= HOLD_EN && w_gnt_vld && !fout_ready_i;
      r_hold_vc <= w_gnt_vc;
      if (fin_valid_i && !w_vc_legal && r_drop_cnt != 8'hff) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
  assign fout_valid_o = w_gnt_vld;
  assign fout_vc_o    = w_gnt_vld ? w_gnt_vc : '0;
  assign fout_data_o  = w_gnt_vld ? w_head : '0;
  assign vc_full_o    = w_full;
  assign vc_empty_o   = w_empty;
  assign drop_cnt_o   = r_drop_cnt;
endmodule

// File: tb/tb_vc_input_datapath.sv
// tb_vc_input_datapath: four datapath variants driven with shared stimulus, each checked
// every cycle against a queue-based model of the arbitration and locking rules.
module tb_vc_input_datapath;
  import ravenoc_pkg::*;
  localparam int NI    = 4;
  localparam int NV    = 3;
  localparam int DEPTH = 4;
  localparam int W     = 34;
  localparam int MODE [NI] = '{2, 2, 0, 1};
  localparam int LK   [NI] = '{1, 0, 0, 0};
  logic          clk = 1'b0;
  logic          arst;
  logic          fin_valid;
  logic [1:0]    fin_vc;
  logic [W-1:0]  fin_data;
  logic          fout_ready;
  logic          o_rdy   [NI];
  logic          o_vld   [NI];
  logic [1:0]    o_vc    [NI];
  logic [W-1:0]  o_data  [NI];
  logic [NV-1:0] o_full  [NI];
  logic [NV-1:0] o_empty [NI];
  logic [7:0]    o_drop  [NI];
  logic [W-1:0]  q [NI][NV][$];
  int            lock_vc [NI];
  int            rr      [NI];
  int            hold_vc [NI];
  int            drops   [NI];
  int            n_chk = 0;
  int            n_pass = 0;
  int            seq_vc [$];
  logic [W-1:0]  seq_dat [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    vc_input_datapath #(
      .FLIT_WIDTH(W),
      .N_VC      (NV),
      .VC_DEPTH  (DEPTH),
      .ARB_MODE  (MODE[g]),
      .PKT_LOCK  (LK[g])
    ) u_dut (
      .clk         (clk),
      .arst        (arst),
      .fin_valid_i (fin_valid),
      .fin_vc_i    (fin_vc),
      .fin_data_i  (fin_data),
      .fin_ready_o (o_rdy[g]),
      .fout_valid_o(o_vld[g]),
      .fout_vc_o   (o_vc[g]),
      .fout_data_o (o_data[g]),
      .fout_ready_i(fout_ready),
      .vc_full_o   (o_full[g]),
      .vc_empty_o  (o_empty[g]),
      .drop_cnt_o  (o_drop[g])
    );
  end
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  function automatic logic [W-1:0] mk(input logic [1:0] t);
    return {t, 32'($urandom)};
  endfunction
  // Model grant: lock first, then a still-pending grant, then the mode's search order.
  function automatic int pick(input int k);
    if (lock_vc[k] >= 0) return q[k][lock_vc[k]].size() > 0 ? lock_vc[k] : -1;
    if (hold_vc[k] >= 0) return hold_vc[k];
    for (int i = 0; i < NV; i++) begin
      int v;
      v = MODE[k] == 0 ? NV - 1 - i : MODE[k] == 1 ? i : (rr[k] + i) % NV;
      if (q[k][v].size() > 0) return v;
    end
    return -1;
  endfunction
  task automatic do_reset();
    fin_valid  = 1'b0;
    fin_vc     = 2'd0;
    fin_data   = '0;
    fout_ready = 1'b0;
    arst       = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_vld%0d", k), o_vld[k], 0);
      check($sformatf("rst_vc%0d", k), o_vc[k], 0);
      check($sformatf("rst_data%0d", k), o_data[k], 0);
      check($sformatf("rst_empty%0d", k), o_empty[k], 3'b111);
      check($sformatf("rst_full%0d", k), o_full[k], 0);
      check($sformatf("rst_drop%0d", k), o_drop[k], 0);
      check($sformatf("rst_rdy%0d", k), o_rdy[k], 1);
      for (int v = 0; v < NV; v++) q[k][v].delete();
      lock_vc[k] = -1;
      rr[k]      = 0;
      hold_vc[k] = -1;
      drops[k]   = 0;
    end
    @(posedge clk);
    #1;
    arst = 1'b1;
  endtask
  task automatic cycle(input logic v, input logic [1:0] vc, input logic [W-1:0] d, input logic rdy);
    int   g   [NI];
    logic acc [NI];
    fin_valid  = v;
    fin_vc     = vc;
    fin_data   = d;
    fout_ready = rdy;
    #3;
    for (int k = 0; k < NI; k++) begin
      logic [NV-1:0] ev;
      logic [NV-1:0] fv;
      g[k]   = pick(k);
      acc[k] = v && vc < NV && q[k][vc].size() < DEPTH;
      for (int x = 0; x < NV; x++) begin
        ev[x] = q[k][x].size() == 0;
        fv[x] = q[k][x].size() == DEPTH;
      end
      check($sformatf("rdy%0d", k), o_rdy[k], vc >= NV || q[k][vc].size() < DEPTH);
      check($sformatf("vld%0d", k), o_vld[k], g[k] >= 0);
      if (g[k] >= 0) begin
        check($sformatf("vc%0d", k), o_vc[k], g[k]);
        check($sformatf("data%0d", k), o_data[k], q[k][g[k]][0]);
      end
      check($sformatf("empty%0d", k), o_empty[k], ev);
      check($sformatf("full%0d", k), o_full[k], fv);
      check($sformatf("drop%0d", k), o_drop[k], drops[k]);
    end
    if (o_vld[1] && rdy) begin
      seq_vc.push_back(int'(o_vc[1]));
      seq_dat.push_back(o_data[1]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (g[k] >= 0 && rdy) begin
        logic [1:0] ty;
        ty = q[k][g[k]][0][W-1 -: 2];
        void'(q[k][g[k]].pop_front());
        if (LK[k] != 0 && lock_vc[k] < 0 && ty == FLIT_HEAD) lock_vc[k] = g[k];
        else if (LK[k] != 0 && lock_vc[k] >= 0 && ty == FLIT_TAIL) lock_vc[k] = -1;
        if (LK[k] == 0 || ty == FLIT_TAIL || ty == FLIT_HEAD_TAIL) rr[k] = (g[k] + 1) % NV;
        hold_vc[k] = -1;
      end else begin
        hold_vc[k] = (g[k] >= 0 && (LK[k] != 0 || MODE[k] == 2)) ? g[k] : -1;
      end
      if (acc[k]) q[k][vc].push_back(d);
      if (v && vc >= NV && drops[k] < 255) drops[k]++;
    end
    #1;
  endtask
  initial begin
    logic [W-1:0] sent [4];
    int           exp_rr [6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    // Fill VC1 to depth, then drain in order.
    for (int i = 0; i < 4; i++) begin
      sent[i] = mk(FLIT_HEAD_TAIL);
      cycle(1'b1, 2'd1, sent[i], 1'b0);
    end
    fin_vc    = 2'd1;
    fin_valid = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("vc1_full%0d", k), o_full[k][1], 1);
      check($sformatf("vc1_rdy%0d", k), o_rdy[k], 0);
    end
    seq_vc.delete();
    seq_dat.delete();
    cycle(1'b1, 2'd1, mk(FLIT_HEAD_TAIL), 1'b0);
    repeat (5) cycle(1'b0, 2'd0, '0, 1'b1);
    check("drain_cnt", seq_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), seq_dat[i], sent[i]);
      check($sformatf("drain_vc%0d", i), seq_vc[i], 1);
    end
    // Round-robin alternation and fixed-priority selection on the same contents.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'(i % 2), mk(FLIT_HEAD_TAIL), 1'b0);
    check("fixhi_vld", o_vld[2], 1);
    check("fixhi_vc", o_vc[2], 1);
    check("fixlo_vld", o_vld[3], 1);
    check("fixlo_vc", o_vc[3], 0);
    seq_vc.delete();
    seq_dat.delete();
    repeat (8) cycle(1'b0, 2'd0, '0, 1'b1);
    check("rr_cnt", seq_vc.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("rr_seq%0d", i), seq_vc[i], exp_rr[i]);
    // Packet lock: VC0 must wait until VC1's TAIL has gone.
    do_reset();
    cycle(1'b1, 2'd1, mk(FLIT_HEAD), 1'b1);
    cycle(1'b1, 2'd1, mk(FLIT_BODY), 1'b1);
    cycle(1'b1, 2'd0, mk(FLIT_HEAD_TAIL), 1'b1);
    check("lock_wait_vld", o_vld[0], 0);
    check("lock_wait_vc0", o_empty[0][0], 0);
    cycle(1'b0, 2'd0, '0, 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);
    check("lock_still_vld", o_vld[0], 0);
    cycle(1'b1, 2'd1, mk(FLIT_TAIL), 1'b1);
    check("lock_tail_vc", o_vc[0], 1);
    cycle(1'b0, 2'd0, '0, 1'b1);
    check("unlock_vld", o_vld[0], 1);
    check("unlock_vc", o_vc[0], 0);
    repeat (2) cycle(1'b0, 2'd0, '0, 1'b1);
    // Illegal VC: always accepted, never stored, counter saturates.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, mk(2'($urandom)), 1'($urandom));
    for (int k = 0; k < NI; k++) begin
      check($sformatf("drop_sat%0d", k), o_drop[k], 255);
      check($sformatf("drop_empty%0d", k), o_empty[k], 3'b111);
    end
    // Reset in the middle of a locked packet.
    do_reset();
    cycle(1'b1, 2'd0, mk(FLIT_HEAD), 1'b1);
    cycle(1'b1, 2'd0, mk(FLIT_BODY), 1'b1);
    cycle(1'b1, 2'd0, mk(FLIT_BODY), 1'b0);
    check("mid_stored", o_empty[0][0], 0);
    do_reset();
    cycle(1'b1, 2'd1, mk(FLIT_HEAD), 1'b0);
    cycle(1'b0, 2'd0, '0, 1'b0);
    check("post_rst_vld", o_vld[0], 1);
    check("post_rst_vc", o_vc[0], 1);
    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), mk(2'($urandom)), $urandom_range(0, 9) < 7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
